// File: rtl/data_mem_responder.sv
// Single-port load/store responder over DEPTH_WORDS x 32-bit memory; rsp_valid 2 cycles after accept, held until rsp_ready.
// req_ready only in IDLE. DATA_MEM_MISALIGN_TRAP_EN: misaligned h/w rejected instead of being force-aligned.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_rd_word;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          range_err, funct3_err, req_err;
  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  // Decode of the registered request; lane is the force-aligned byte offset.
  always_comb begin
    idx        = addr_q[AW+1:2];
    lane       = addr_q[1:0];
    if (funct3_q[1:0] == 2'b01) lane[0] = 1'b0;
    if (funct3_q[1:0] == 2'b10) lane    = 2'b00;
    range_err  = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    funct3_err = (funct3_q == 3'b011) || (funct3_q == 3'b110) ||
                 (funct3_q == 3'b111) || (write_q && funct3_q[2]);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    req_err    = range_err || funct3_err ||
                 ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    req_err    = range_err || funct3_err;
`endif
  end

  always_comb begin
    be         = 4'hF;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Memory has no reset; rst suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && !req_err) begin
      if (state_q == READ) mem_rd_word <= mem[idx];
      if (state_q == WRITE) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= lane_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    shifted  = mem_rd_word >> {lane, 3'b000};
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          state_d  = req_write ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        rsp_err_d = req_err;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = ((state_q == RESP) && !write_q && !rsp_err_q) ? load_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads/stores, stall, errors, reset mid-transaction.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd;
  logic        er;

  data_mem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // One full transaction with rsp_ready high; checks the 2-cycle latency.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    drive(w, f3, a, wd);
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'd2);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw10_err", 32'(er), 32'd0);
    chk("sw10_rdata", rd, 32'd0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw10_rdata", rd, 32'hDEADBEEF);
    chk("lw10_err", 32'(er), 32'd0);

    xact("sb11", 1'b1, 3'b000, 32'h11, 32'h00000080, rd, er);
    chk("sb11_err", 32'(er), 32'd0);
    xact("lb11", 1'b0, 3'b000, 32'h11, 32'h0, rd, er);
    chk("lb11_rdata", rd, 32'hFFFFFF80);
    xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, rd, er);
    chk("lbu11_rdata", rd, 32'h00000080);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw10b_rdata", rd, 32'hDEAD80EF);
    xact("lh12", 1'b0, 3'b001, 32'h12, 32'h0, rd, er);
    chk("lh12_rdata", rd, 32'hFFFFDEAD);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, rd, er);
    chk("lhu12_rdata", rd, 32'h0000DEAD);

    // Response stall with a second request held valid throughout.
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b0, 3'b100, 32'h10, 32'h0);
    @(negedge clk);
    chk("stall_read_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, 32'hDEAD80EF);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_read_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rdata", rsp_rdata, 32'h000000EF);
    @(posedge clk);
    #1;

    xact("lw12", 1'b0, 3'b010, 32'h12, 32'h0, rd, er);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    chk("lw12_err", 32'(er), 32'd1);
    chk("lw12_rdata", rd, 32'd0);
`else
    chk("lw12_err", 32'(er), 32'd0);
    chk("lw12_rdata", rd, 32'hDEAD80EF);
`endif

    // Out-of-range store must not alias onto word 0.
    xact("sw0", 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, rd, er);
    xact("sw_oor", 1'b1, 3'b010, 32'h1000, 32'h11111111, rd, er);
    chk("sw_oor_err", 32'(er), 32'd1);
    xact("lw0", 1'b0, 3'b010, 32'h0, 32'h0, rd, er);
    chk("lw0_rdata", rd, 32'hCAFEF00D);
    xact("lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0, rd, er);
    chk("lw_oor_err", 32'(er), 32'd1);
    chk("lw_oor_rdata", rd, 32'd0);
    xact("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, rd, er);
    chk("f3_011_err", 32'(er), 32'd1);
    chk("f3_011_rdata", rd, 32'd0);
    xact("sbu", 1'b1, 3'b100, 32'h10, 32'h0, rd, er);
    chk("sbu_err", 32'(er), 32'd1);
    xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw10c_rdata", rd, 32'hDEAD80EF);

    // Reset during WRITE abandons the store.
    xact("sw20", 1'b1, 3'b010, 32'h20, 32'hAAAA5555, rd, er);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h20, 32'h12345678);
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, rd, er);
    chk("lw20_rdata", rd, 32'hAAAA5555);
    chk("lw20_err", 32'(er), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning 32-bit words of storage (power of two).
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have req_valid  input  1  initiator presents a load/store request.
REQ-005 SHALL have req_ready  output  1  responder can accept a request this cycle.
REQ-006 SHALL have req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have req_funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have req_addr  input  32  byte address.
REQ-009 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have rsp_valid  output  1  response available.
REQ-011 SHALL have rsp_ready  input  1  initiator accepts response.
REQ-012 SHALL have rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores.
REQ-013 SHALL have rsp_err  output  1  request was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-014 SHALL implement FSM IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request when req_valid & req_ready, registering write, funct3, addr and wdata.
REQ-016 SHALL go IDLE->READ on accepted load, IDLE->WRITE on accepted store, READ/WRITE->RESP unconditionally, and RESP->IDLE when rsp_ready.
REQ-017 SHALL assert rsp_valid exactly 2 cycles after acceptance and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
REQ-018 SHALL block new requests while in RESP, even when rsp_ready is high in the same cycle; the next acceptance is no earlier than the following cycle.
REQ-019 SHALL read memory synchronously in READ, then select bytes by addr[1:0]: b/h sign-extend, bu/hu zero-extend, w pass through.
REQ-020 SHALL commit stores on the WRITE->RESP edge using byte enables: b writes 1 lane at addr[1:0], h writes 2 lanes at addr[1], w writes all 4 lanes, taking data from req_wdata low bits shifted to the lane.
REQ-021 SHALL treat addr[31:2] >= DEPTH_WORDS as out of range: no memory write, rsp_rdata = 0, rsp_err = 1.
REQ-022 SHALL treat funct3 011, 110, 111, and store funct3 100/101, as illegal: no memory access, rsp_err = 1, rsp_rdata = 0.
REQ-023 SHALL still traverse READ/WRITE for rejected requests, so latency is constant.
REQ-024 SHALL ignore req_* inputs outside IDLE; a req_valid held through a busy period is accepted on return to IDLE.

Reset
REQ-025 SHALL on rst force state IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 1 on the first cycle after reset.
REQ-026 SHALL NOT reset memory contents.
REQ-027 SHALL abandon an in-flight request when rst is asserted in READ or WRITE, with no memory write performed; rst in RESP drops the response.
REQ-028 SHALL give rst priority over every other event in the same cycle.

Configuration
REQ-029 SHALL honour macro DATA_MEM_MISALIGN_TRAP_EN.
REQ-030 When defined: h/hu with addr[0] = 1, or w with addr[1:0] != 0, SHALL set rsp_err = 1, perform no write, and return rsp_rdata = 0.
REQ-031 When undefined: the low address bits SHALL be forced to alignment (h clears bit 0, w clears bits 1:0), the access SHALL proceed, and rsp_err SHALL report only range and funct3 errors.

Verification
REQ-032 Bench SHALL cover: sw 0xDEADBEEF @0x10, lw @0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each acceptance.
REQ-033 Bench SHALL cover: after REQ-032, sb 0x80 @0x11, then lb @0x11 -> 0xFFFFFF80, lbu @0x11 -> 0x00000080, lw @0x10 -> 0xDEAD80EF.
REQ-034 Bench SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0 throughout, back-to-back req_valid accepted only after the handshake.
REQ-035 Bench SHALL cover: lw @0x12 -> with macro rsp_err 1, rdata 0; without macro rdata = word @0x10, rsp_err 0.
REQ-036 Bench SHALL cover: sw @(DEPTH_WORDS*4) -> rsp_err 1 and memory unchanged; funct3 011 -> rsp_err 1.
REQ-037 Bench SHALL cover: sw 0x12345678 @0x20 with rst pulsed in WRITE -> rsp_valid 0 next cycle, lw @0x20 returns the prior value.
